multi_digit_display: RTL
========================

Name: multi_digit_display

Overview:
Parametrised successor to the two-digit seven-segment driver and clock divider pair. Displays an N-digit value on a multiplexed common-anode display. Takes a register value (e.g. debug register $23) and shows it in hex or in decimal. Decimal conversion uses a sequential double-dabble engine, and the refresh prescaler is built in, so no external divided clock is needed. Sits at the datapath top level, fed directly from the register-file debug port.

Parameters:
NUM_DIGITS, 4, number of digits scanned (1..8)
DATA_WIDTH, 32, width of Number input
REFRESH_DIV, 100000, Clock cycles each digit stays enabled (>=2)

Ports:
Clock  in  1  system clock, all state on rising edge
Reset  in  1  asynchronous, active-low; clears all state
Number  in  DATA_WIDTH  value to display, unsigned
Mode  in  1  0 = hex, 1 = unsigned decimal
out7  out  7  segments {a,b,c,d,e,f,g}, active-low
en_out  out  NUM_DIGITS  digit anode enables, active-low; bit 0 = least significant digit
Busy  out  1  conversion in progress
Overflow  out  1  value does not fit in NUM_DIGITS digits (sticky until next commit)

Behaviour:
- Reset (Reset=0, async): out7=7'b1111111, en_out=all ones, Busy=0, Overflow=0, digit buffer=0, prescaler=0, scan index=0, captured-valid flag=0.
- Converter FSM has three states: IDLE, CONV, DONE.
- IDLE -> capture: at an edge where valid=0 or {Number,Mode} != captured copy, capture Number/Mode and set valid=1.
  - Hex mode: go to DONE.
  - Decimal mode: go to CONV with shift count = DATA_WIDTH and BCD register (4*NUM_DIGITS bits) = 0.
- CONV: each edge, first add 3 to every BCD nibble >=5, then shift {BCD, value} left by 1. If a 1 shifts out of the BCD MSB, set the internal overflow flag. After DATA_WIDTH shifts, go to DONE.
- DONE: commit the result to the digit buffer atomically and update Overflow, then return to IDLE.
  - Hex result = low 4*NUM_DIGITS bits of the captured value. Overflow=1 if any higher bits are nonzero.
  - Decimal result = BCD register. Overflow = internal flag.
- Busy=1 in CONV and DONE.
- Latency from the capturing edge to committed buffer: hex 1 edge; decimal DATA_WIDTH+1 edges.
- Number/Mode changes while Busy are ignored until IDLE, then re-evaluated. A change that reverts before IDLE is not displayed.
- The buffer is never partially updated. The display shows the old value until commit.
- Scan prescaler counts 0..REFRESH_DIV-1. On wrap, the scan index advances 0..NUM_DIGITS-1, then wraps to 0.
- out7 and en_out are registered, updated one cycle after the index change. Exactly one en_out bit is low at any time after the first edge following reset; the enabled bit is en_out[index].
- Glyphs, active-low (0 = segment on):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
  - A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000
- Reset asserted mid-conversion aborts it. After release, valid=0 forces a fresh conversion of the current Number.
- Overflow does not blank the display; the truncated low digits are shown.

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined: every zero digit above the most significant nonzero digit shows out7=7'b1111111. Digit 0 is always shown, so value 0 shows a single "0". Blanking is decided from the committed buffer. The anode is still enabled.
- Undefined: all NUM_DIGITS digits are shown, including leading zeros.

Test Plan:
1. Reset held low with Number=32'h1234 -> out7=1111111, en_out=1111, Busy=0. Release with REFRESH_DIV=4 and Mode=0 -> commit after 1 edge; digits 0..3 show 4,3,2,1 (1001100, 0000110, 0010010, 1001111) with en_out cycling 1110, 1101, 1011, 0111, each held 4 cycles.
2. Mode=1, Number=32'd9876 -> Busy high for 33 edges; digits show 6,8,7,9; Overflow=0.
3. Mode=1, Number=32'd12345, NUM_DIGITS=4 -> display 2345, Overflow=1. Mode=0, Number=32'h0001_0000 -> display 0000, Overflow=1.
4. Change Number to 32'd42 during CONV, revert to the original before IDLE -> no second conversion, display unchanged. Change Number and hold -> reconversion starts on the first edge in IDLE.
5. Assert Reset at shift 10 of a decimal conversion -> all outputs return to reset values immediately. After release, the current Number is fully reconverted.
6. With LEADING_ZERO_BLANK_EN, Mode=1, Number=7 -> digits 3..1 show 1111111, digit 0 shows 0001111. Number=0 -> only digit 0 shows 0000001.

Source files
------------

// File: rtl/multi_digit_display.sv
// multi_digit_display: N-digit multiplexed common-anode driver, hex or decimal (double-dabble).
// Define LEADING_ZERO_BLANK_EN to blank zero digits above the most significant nonzero digit.
module multi_digit_display #(
    parameter int NUM_DIGITS  = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [DATA_WIDTH-1:0] Number,
    input  logic                  Mode,
    output logic [6:0]            out7,
    output logic [NUM_DIGITS-1:0] en_out,
    output logic                  Busy,
    output logic                  Overflow
);
    localparam int BW = 4 * NUM_DIGITS;
    localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam int PW = $clog2(REFRESH_DIV);
    localparam int CW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] num_q, num_d, val_q, val_d;
    logic                  mode_q, mode_d, valid_q, valid_d;
    logic [BW-1:0]         bcd_q, bcd_d, buf_q, buf_d, bcd_adj, hex_res;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  ovf_int_q, ovf_int_d, ovf_q, ovf_d;
    logic [BW+DATA_WIDTH-1:0] num_ext;
    logic [PW-1:0]         pre_q, pre_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [6:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] en_q, en_d;
    logic [3:0]            digit;
    logic                  blank;

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'h0: glyph = 7'b0000001;
            4'h1: glyph = 7'b1001111;
            4'h2: glyph = 7'b0010010;
            4'h3: glyph = 7'b0000110;
            4'h4: glyph = 7'b1001100;
            4'h5: glyph = 7'b0100100;
            4'h6: glyph = 7'b0100000;
            4'h7: glyph = 7'b0001111;
            4'h8: glyph = 7'b0000000;
            4'h9: glyph = 7'b0000100;
            4'hA: glyph = 7'b0001000;
            4'hB: glyph = 7'b1100000;
            4'hC: glyph = 7'b0110001;
            4'hD: glyph = 7'b1000010;
            4'hE: glyph = 7'b0110000;
            default: glyph = 7'b0111000;
        endcase
    endfunction

    assign num_ext = {{BW{1'b0}}, num_q};
    assign hex_res = num_ext[BW-1:0];

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < NUM_DIGITS; i++)
            bcd_adj[4*i+:4] = bcd_q[4*i+:4] >= 4'd5 ? bcd_q[4*i+:4] + 4'd3 : bcd_q[4*i+:4];
    end

    always_comb begin
        state_d   = state_q;
        num_d     = num_q;
        mode_d    = mode_q;
        valid_d   = valid_q;
        val_d     = val_q;
        bcd_d     = bcd_q;
        cnt_d     = cnt_q;
        ovf_int_d = ovf_int_q;
        buf_d     = buf_q;
        ovf_d     = ovf_q;
        case (state_q)
            IDLE: if (!valid_q || Number != num_q || Mode != mode_q) begin
                num_d     = Number;
                mode_d    = Mode;
                valid_d   = 1'b1;
                val_d     = Number;
                bcd_d     = '0;
                cnt_d     = CW'(DATA_WIDTH);
                ovf_int_d = 1'b0;
                state_d   = Mode ? CONV : DONE;
            end
            CONV: begin
                {bcd_d, val_d} = {bcd_adj[BW-2:0], val_q, 1'b0};
                ovf_int_d      = ovf_int_q | bcd_adj[BW-1];
                cnt_d          = cnt_q - CW'(1);
                state_d        = cnt_q == CW'(1) ? DONE : CONV;
            end
            DONE: begin
                buf_d   = mode_q ? bcd_q : hex_res;
                ovf_d   = mode_q ? ovf_int_q : |num_ext[BW+DATA_WIDTH-1:BW];
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Display path reads only the committed buffer, so a conversion never shows partially.
    always_comb begin
        pre_d = pre_q == PW'(REFRESH_DIV - 1) ? '0 : pre_q + PW'(1);
        idx_d = pre_q != PW'(REFRESH_DIV - 1) ? idx_q :
                idx_q == IW'(NUM_DIGITS - 1) ? '0 : idx_q + IW'(1);
        digit = buf_q[4*idx_q+:4];
`ifdef LEADING_ZERO_BLANK_EN
        blank = idx_q != '0 && (buf_q >> (4 * idx_q)) == '0;
`else
        blank = 1'b0;
`endif
        seg_d = blank ? 7'b1111111 : glyph(digit);
        en_d  = ~(NUM_DIGITS'(1) << idx_q);
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q   <= IDLE;
            num_q     <= '0;
            mode_q    <= 1'b0;
            valid_q   <= 1'b0;
            val_q     <= '0;
            bcd_q     <= '0;
            cnt_q     <= '0;
            ovf_int_q <= 1'b0;
            buf_q     <= '0;
            ovf_q     <= 1'b0;
            pre_q     <= '0;
            idx_q     <= '0;
            seg_q     <= 7'b1111111;
            en_q      <= '1;
        end else begin
            state_q   <= state_d;
            num_q     <= num_d;
            mode_q    <= mode_d;
            valid_q   <= valid_d;
            val_q     <= val_d;
            bcd_q     <= bcd_d;
            cnt_q     <= cnt_d;
            ovf_int_q <= ovf_int_d;
            buf_q     <= buf_d;
            ovf_q     <= ovf_d;
            pre_q     <= pre_d;
            idx_q     <= idx_d;
            seg_q     <= seg_d;
            en_q      <= en_d;
        end
    end

    assign out7     = seg_q;
    assign en_out   = en_q;
    assign Busy     = state_q != IDLE;
    assign Overflow = ovf_q;
endmodule
